// File: rtl/instr_loader.sv
// instr_loader: receives a framed instruction image byte by byte, writes it to instruction memory and releases the core when the checksum matches.
module instr_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [20:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {HDR_HI, HDR_LO, B0, B1, B2, WRITE, CHK, DONE, ERR} state_t;
    state_t state, next;
    logic [11:0] len, cnt, cnt_inc;
    logic [7:0]  sum, mid;
    logic [4:0]  hi;
    logic        xfer;
    assign in_ready   = !(state == WRITE || state == DONE || state == ERR);
    assign xfer       = in_valid && in_ready;
    assign cnt_inc    = cnt + 12'd1;
    assign imem_we    = state == WRITE;
    assign done       = state == DONE;
    assign err        = state == ERR;
    assign core_rst_n = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst) state <= HDR_HI;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            HDR_HI: next = in_valid ? HDR_LO : HDR_HI;
            HDR_LO: next = !in_valid ? HDR_LO : ({len[11:8], in_data} == 12'd0) ? ERR : B0;
            B0:     next = !in_valid ? B0 : (in_data[7:5] != 3'd0) ? ERR : B1;
            B1:     next = in_valid ? B2 : B1;
            B2:     next = in_valid ? WRITE : B2;
            WRITE:  next = (cnt_inc == len) ? CHK : B0;
            CHK:    next = !in_valid ? CHK : (in_data == sum) ? DONE : ERR;
            DONE:   next = start ? HDR_HI : DONE;
            ERR:    next = start ? HDR_HI : ERR;
            default: next = HDR_HI;
        endcase
    end
    // Datapath: header length, partial word bytes, running XOR and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len        <= '0;
            cnt        <= '0;
            sum        <= '0;
            hi         <= '0;
            mid        <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                HDR_HI: if (xfer) begin
                    len[11:8] <= in_data[3:0];
                    sum       <= sum ^ in_data;
                end
                HDR_LO: if (xfer) begin
                    len[7:0]  <= in_data;
                    sum       <= sum ^ in_data;
                    cnt       <= '0;
                    imem_addr <= '0;
                end
                B0: if (xfer) begin
                    hi  <= in_data[4:0];
                    sum <= sum ^ in_data;
                end
                B1: if (xfer) begin
                    mid <= in_data;
                    sum <= sum ^ in_data;
                end
                B2: if (xfer) begin
                    sum        <= sum ^ in_data;
                    imem_wdata <= {hi, mid, in_data};
                    imem_addr  <= cnt;
                end
                WRITE: cnt <= cnt_inc;
                DONE, ERR: if (start) begin
                    cnt <= '0;
                    sum <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
